// File: rtl/jtframe_rom_arb_if.sv
// Slot-side request/data ports and SDRAM controller read port of jtframe_rom_arb.
// The arbiter uses the slave modport; the game/controller side uses master.
interface jtframe_rom_arb_if #(
    parameter int AW = 22,
    parameter int DW = 32
);
    logic            loop_rst;
    logic            downloading;
    logic [3:0]      slot_cs;
    logic [4*AW-1:0] slot_addr;
    logic [3:0]      slot_ok;
    logic [4*DW-1:0] slot_dout;
    logic            sdram_req;
    logic [AW-1:0]   sdram_addr;
    logic            sdram_ack;
    logic [DW-1:0]   data_read;
    logic            data_rdy;
    logic            busy;

    modport master (
        output loop_rst, downloading, slot_cs, slot_addr, sdram_ack, data_read, data_rdy,
        input  slot_ok, slot_dout, sdram_req, sdram_addr, busy
    );

    modport slave (
        input  loop_rst, downloading, slot_cs, slot_addr, sdram_ack, data_read, data_rdy,
        output slot_ok, slot_dout, sdram_req, sdram_addr, busy
    );
endinterface

// File: rtl/jtframe_rom_arb.sv
// Four-slot round-robin SDRAM read arbiter; each slot caches its last fetched word
// so that a repeated address is answered without touching the SDRAM.
module jtframe_rom_arb #(
    parameter int AW = 22,
    parameter int DW = 32
) (
    input  logic             clk_rom,
    input  logic             rst,
    jtframe_rom_arb_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT_ACK, ST_WAIT_RDY} state_t;

    state_t        r_state, w_state_next;
    logic [1:0]    r_gnt, w_gnt_next;
    logic [1:0]    r_last, w_last_next;
    logic          r_req, w_req_next;
    logic [AW-1:0] r_addr, w_addr_next;
    logic          w_fill;
    logic          w_flush;
    logic          w_any;
    logic [1:0]    w_off, w_sel;
    logic [3:0]    w_pend, w_rot, w_ok;
    logic [AW-1:0] w_slot_addr [4];

    assign w_flush = bus.loop_rst | bus.downloading;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            logic [AW-1:0] r_cache_addr;
            logic [DW-1:0] r_cache_data;
            logic          r_valid;
            logic          r_ok;
            logic          w_hit;

            assign w_slot_addr[gi] = bus.slot_addr[gi*AW +: AW];
            assign w_hit           = r_valid && (w_slot_addr[gi] == r_cache_addr);
            assign w_pend[gi]      = bus.slot_cs[gi] & ~w_hit;
            // w_rot[0] is the slot right after the last served one
            assign w_rot[gi]       = w_pend[2'(r_last + 2'(gi + 1))];
            assign w_ok[gi]        = r_ok;
            assign bus.slot_dout[gi*DW +: DW] = r_cache_data;

            always_ff @(posedge clk_rom or posedge rst) begin
                if (rst) begin
                    r_cache_addr <= '0;
                    r_cache_data <= '0;
                    r_valid      <= 1'b0;
                    r_ok         <= 1'b0;
                end else if (w_flush) begin
                    r_valid <= 1'b0;
                    r_ok    <= 1'b0;
                end else begin
                    r_ok <= bus.slot_cs[gi] & w_hit;
                    // Fill stores the latched address, even if the slot moved on meanwhile
                    if (w_fill && r_gnt == 2'(gi)) begin
                        r_cache_addr <= r_addr;
                        r_cache_data <= bus.data_read;
                        r_valid      <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        w_off = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_rot[i]) w_off = 2'(i);
        end
    end

    assign w_any = |w_rot;
    assign w_sel = r_last + 2'd1 + w_off;

    always_comb begin
        w_state_next = r_state;
        w_gnt_next   = r_gnt;
        w_last_next  = r_last;
        w_req_next   = r_req;
        w_addr_next  = r_addr;
        w_fill       = 1'b0;
        if (w_flush) begin
            w_state_next = ST_IDLE;
            w_req_next   = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        w_gnt_next   = w_sel;
                        w_addr_next  = w_slot_addr[w_sel];
                        w_req_next   = 1'b1;
                        w_state_next = ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (bus.sdram_ack) begin
                        w_req_next = 1'b0;
                        if (bus.data_rdy) begin
                            w_fill       = 1'b1;
                            w_last_next  = r_gnt;
                            w_state_next = ST_IDLE;
                        end else begin
                            w_state_next = ST_WAIT_RDY;
                        end
                    end
                end
                ST_WAIT_RDY: begin
                    if (bus.data_rdy) begin
                        w_fill       = 1'b1;
                        w_last_next  = r_gnt;
                        w_state_next = ST_IDLE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_rom or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= 2'd0;
            r_last  <= 2'd3;
            r_req   <= 1'b0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_next;
            r_gnt   <= w_gnt_next;
            r_last  <= w_last_next;
            r_req   <= w_req_next;
            r_addr  <= w_addr_next;
        end
    end

    assign bus.slot_ok    = w_ok;
    assign bus.sdram_req  = r_req;
    assign bus.sdram_addr = r_addr;
    assign bus.busy       = (r_state != ST_IDLE);
endmodule

// File: tb/tb_jtframe_rom_arb.sv
// Self-checking bench for jtframe_rom_arb: the bench plays the SDRAM controller and
// predicts grants and cache contents from a per-slot model of the arbitration rules.
module tb_jtframe_rom_arb;
    localparam int AW = 22;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jtframe_rom_arb_if #(.AW(AW), .DW(DW)) bus ();
    jtframe_rom_arb #(.AW(AW), .DW(DW)) dut (.clk_rom(clk), .rst(rst), .bus(bus));

    logic [3:0]    cs_v;
    logic [AW-1:0] addr_v [4];
    assign bus.slot_cs   = cs_v;
    assign bus.slot_addr = {addr_v[3], addr_v[2], addr_v[1], addr_v[0]};

    // reference model: what each slot should hold and who was served last
    bit            m_valid [4];
    logic [AW-1:0] m_addr  [4];
    logic [DW-1:0] m_data  [4];
    int            m_last;

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        for (int n = 0; n < 4; n++) begin
            m_valid[n] = 0;
            m_addr[n]  = '0;
            m_data[n]  = '0;
        end
        m_last = 3;
    endfunction

    function automatic bit model_hit(int n);
        return m_valid[n] && (m_addr[n] == addr_v[n]);
    endfunction

    function automatic int exp_grant();
        for (int i = 1; i <= 4; i++) begin
            int n;
            n = (m_last + i) % 4;
            if (cs_v[n] && !model_hit(n)) return n;
        end
        return -1;
    endfunction

    function automatic void model_fill(int g, logic [AW-1:0] a, logic [DW-1:0] d);
        if (g >= 0) begin
            m_valid[g] = 1;
            m_addr[g]  = a;
            m_data[g]  = d;
            m_last     = g;
        end
    endfunction

    task automatic flush_all();
        bus.loop_rst = 1'b1;
        tick();
        bus.loop_rst = 1'b0;
        for (int n = 0; n < 4; n++) m_valid[n] = 0;
    endtask

    // Waits (bounded) for a request, then answers it; returns with the fill edge just past.
    task automatic serve(input logic [DW-1:0] d, input int gap, input bit both,
                         output logic [AW-1:0] addr_seen, output int wait_cyc);
        wait_cyc = 0;
        while (!bus.sdram_req && wait_cyc < 50) begin
            tick();
            wait_cyc++;
        end
        addr_seen = bus.sdram_addr;
        if (!bus.sdram_req) return;
        repeat (gap) tick();
        bus.sdram_ack = 1'b1;
        if (both) begin
            bus.data_read = d;
            bus.data_rdy  = 1'b1;
        end
        tick();
        bus.sdram_ack = 1'b0;
        bus.data_rdy  = 1'b0;
        if (!both) begin
            repeat (gap) tick();
            bus.data_read = d;
            bus.data_rdy  = 1'b1;
            tick();
            bus.data_rdy  = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int w, g;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++;
        if (bus.sdram_req !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset_req_busy got req=%b busy=%b want 0 0", bus.sdram_req, bus.busy);
        end
        checks++;
        if (bus.sdram_addr !== '0 || bus.slot_ok !== 4'h0 || bus.slot_dout !== '0) begin
            errors++; $display("FAIL reset_outputs got addr=%h ok=%b dout=%h want all 0", bus.sdram_addr, bus.slot_ok, bus.slot_dout);
        end
        addr_v[0] = 22'h00010;
        addr_v[2] = 22'h00020;
        cs_v = 4'b0101;
        g = exp_grant();
        d = $urandom;
        serve(d, 1, 0, a, w);
        checks++;
        if (a !== 22'h00010 || w != 1) begin
            errors++; $display("FAIL first_grant got addr=%h wait=%0d want addr=00010 wait=1", a, w);
        end
        model_fill(g, addr_v[g], d);
        tick();
        checks++;
        if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== 22'h00020) begin
            errors++; $display("FAIL second_grant got req=%b addr=%h want 1 00020", bus.sdram_req, bus.sdram_addr);
        end
        checks++;
        if (bus.slot_ok[0] !== 1'b1 || bus.slot_dout[DW-1:0] !== m_data[0]) begin
            errors++; $display("FAIL slot0_fill got ok=%b dout=%h want 1 %h", bus.slot_ok[0], bus.slot_dout[DW-1:0], m_data[0]);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (bus.sdram_req !== 1'b0 || bus.sdram_addr !== '0 || bus.slot_ok !== 4'h0 ||
            bus.slot_dout !== '0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL async_reset got req=%b addr=%h ok=%b dout=%h busy=%b want all 0",
                               bus.sdram_req, bus.sdram_addr, bus.slot_ok, bus.slot_dout, bus.busy);
        end
        model_reset();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            logic [AW-1:0] want;
            want = (k == 0) ? 22'h00010 : 22'h00020;
            g = exp_grant();
            d = $urandom;
            serve(d, 0, 0, a, w);
            checks++;
            if (a !== want || w != 1) begin
                errors++; $display("FAIL post_reset_order%0d got addr=%h wait=%0d want addr=%h wait=1", k, a, w, want);
            end
            model_fill(g, addr_v[g], d);
        end
        cs_v = 4'b0000;
        tick();
    endtask

    task automatic test_single_hit();
        logic [AW-1:0] a;
        int w, g;
        bit seen;
        flush_all();
        addr_v[1] = 22'h01234;
        cs_v = 4'b0010;
        g = exp_grant();
        serve(32'hDEADBEEF, 1, 0, a, w);
        checks++;
        if (a !== 22'h01234 || w != 1) begin
            errors++; $display("FAIL miss_request got addr=%h wait=%0d want 01234 1", a, w);
        end
        model_fill(g, addr_v[g], 32'hDEADBEEF);
        checks++;
        if (bus.slot_ok[1] !== 1'b0) begin
            errors++; $display("FAIL miss_ok_early got ok1=%b want 0", bus.slot_ok[1]);
        end
        tick();
        checks++;
        if (bus.slot_ok[1] !== 1'b1 || bus.slot_dout[DW +: DW] !== m_data[1]) begin
            errors++; $display("FAIL miss_fill got ok1=%b dout1=%h want 1 %h", bus.slot_ok[1], bus.slot_dout[DW +: DW], m_data[1]);
        end
        cs_v = 4'b0000;
        tick();
        checks++;
        if (bus.slot_ok[1] !== 1'b0) begin
            errors++; $display("FAIL cs_drop got ok1=%b want 0", bus.slot_ok[1]);
        end
        cs_v = 4'b0010;
        tick();
        checks++;
        if (bus.slot_ok[1] !== 1'b1 || bus.sdram_req !== 1'b0) begin
            errors++; $display("FAIL hit_latency got ok1=%b req=%b want 1 0", bus.slot_ok[1], bus.sdram_req);
        end
        seen = 0;
        repeat (4) begin
            tick();
            if (bus.sdram_req !== 1'b0 || bus.slot_ok[1] !== 1'b1) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL hit_steady got req_or_okdrop=%b want 0", seen);
        end
        cs_v = 4'b0000;
        tick();
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] a, lat;
        logic [DW-1:0] d;
        int w, g, obs;
        int cnt [4];
        flush_all();
        for (int n = 0; n < 4; n++) begin
            addr_v[n] = {2'(n), 20'($urandom)};
            cnt[n] = 0;
        end
        cs_v = 4'hF;
        for (int k = 0; k < 16; k++) begin
            g   = exp_grant();
            lat = addr_v[g];
            d   = $urandom;
            serve(d, int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)), a, w);
            obs = -1;
            for (int n = 0; n < 4; n++) if (addr_v[n] === a) obs = n;
            checks++;
            if (obs != g || w != 1) begin
                errors++; $display("FAIL rr_grant%0d got slot=%0d wait=%0d want slot=%0d wait=1", k, obs, w, g);
            end
            if (obs >= 0) cnt[obs]++;
            model_fill(g, lat, d);
            checks++;
            if (bus.slot_dout[g*DW +: DW] !== m_data[g]) begin
                errors++; $display("FAIL rr_dout%0d got %h want %h", k, bus.slot_dout[g*DW +: DW], m_data[g]);
            end
            addr_v[g] = {2'(g), 20'(addr_v[g][19:0] + 20'($urandom_range(1, 1000)))};
        end
        checks++;
        if (cnt[0] != 4 || cnt[1] != 4 || cnt[2] != 4 || cnt[3] != 4) begin
            errors++; $display("FAIL rr_fairness got %0d %0d %0d %0d want 4 each", cnt[0], cnt[1], cnt[2], cnt[3]);
        end
        cs_v = 4'b0000;
        flush_all();
    endtask

    task automatic test_addr_change();
        logic [DW-1:0] d;
        bit exp_ok;
        int w;
        flush_all();
        addr_v[3] = 22'h00100;
        cs_v = 4'b1000;
        w = 0;
        while (!bus.sdram_req && w < 50) begin
            tick();
            w++;
        end
        checks++;
        if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== 22'h00100) begin
            errors++; $display("FAIL ac_request got req=%b addr=%h want 1 00100", bus.sdram_req, bus.sdram_addr);
        end
        bus.sdram_ack = 1'b1;
        tick();
        bus.sdram_ack = 1'b0;
        addr_v[3] = 22'h00200;
        tick();
        tick();
        checks++;
        if (bus.slot_ok[3] !== 1'b0 || bus.busy !== 1'b1 || bus.sdram_req !== 1'b0) begin
            errors++; $display("FAIL ac_wait_rdy got ok3=%b busy=%b req=%b want 0 1 0", bus.slot_ok[3], bus.busy, bus.sdram_req);
        end
        d = $urandom;
        bus.data_read = d;
        bus.data_rdy  = 1'b1;
        tick();
        bus.data_rdy  = 1'b0;
        model_fill(3, 22'h00100, d);
        checks++;
        if (bus.slot_dout[3*DW +: DW] !== m_data[3]) begin
            errors++; $display("FAIL ac_dout got %h want %h", bus.slot_dout[3*DW +: DW], m_data[3]);
        end
        tick();
        checks++;
        if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== 22'h00200 || bus.slot_ok[3] !== 1'b0) begin
            errors++; $display("FAIL ac_rerequest got req=%b addr=%h ok3=%b want 1 00200 0", bus.sdram_req, bus.sdram_addr, bus.slot_ok[3]);
        end
        addr_v[3] = 22'h00100;
        tick();
        exp_ok = cs_v[3] && model_hit(3);
        checks++;
        if (bus.slot_ok[3] !== exp_ok) begin
            errors++; $display("FAIL ac_stored_addr got ok3=%b want %b", bus.slot_ok[3], exp_ok);
        end
        cs_v = 4'b0000;
        flush_all();
        tick();
    endtask

    task automatic test_flush();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int w, g;
        bit seen;
        flush_all();
        addr_v[0] = 22'h00333;
        addr_v[1] = 22'h00444;
        cs_v = 4'b0001;
        g = exp_grant();
        d = $urandom;
        serve(d, 0, 0, a, w);
        model_fill(g, addr_v[g], d);
        tick();
        checks++;
        if (bus.slot_ok[0] !== model_hit(0)) begin
            errors++; $display("FAIL fl_prefill got ok0=%b want %b", bus.slot_ok[0], model_hit(0));
        end
        cs_v = 4'b0011;
        g = exp_grant();
        tick();
        checks++;
        if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== addr_v[g]) begin
            errors++; $display("FAIL fl_request got req=%b addr=%h want 1 %h", bus.sdram_req, bus.sdram_addr, addr_v[g]);
        end
        bus.loop_rst = 1'b1;
        tick();
        bus.loop_rst = 1'b0;
        for (int n = 0; n < 4; n++) m_valid[n] = 0;
        checks++;
        if (bus.sdram_req !== 1'b0 || bus.busy !== 1'b0 || bus.slot_ok !== 4'h0) begin
            errors++; $display("FAIL fl_clear got req=%b busy=%b ok=%b want 0 0 0000", bus.sdram_req, bus.busy, bus.slot_ok);
        end
        g = exp_grant();
        bus.data_read = $urandom;
        bus.data_rdy  = 1'b1;
        tick();
        bus.data_rdy  = 1'b0;
        checks++;
        if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== addr_v[g]) begin
            errors++; $display("FAIL fl_regrant got req=%b addr=%h want 1 %h", bus.sdram_req, bus.sdram_addr, addr_v[g]);
        end
        tick();
        checks++;
        if (bus.slot_ok !== 4'h0) begin
            errors++; $display("FAIL fl_late_rdy got ok=%b want 0000", bus.slot_ok);
        end
        bus.downloading = 1'b1;
        tick();
        checks++;
        if (bus.sdram_req !== 1'b0) begin
            errors++; $display("FAIL dl_drop got req=%b want 0", bus.sdram_req);
        end
        seen = 0;
        repeat (10) begin
            tick();
            if (bus.sdram_req !== 1'b0 || bus.busy !== 1'b0) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL dl_inhibit got grant_seen=%b want 0", seen);
        end
        bus.downloading = 1'b0;
        g = exp_grant();
        tick();
        checks++;
        if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== addr_v[g]) begin
            errors++; $display("FAIL dl_release got req=%b addr=%h want 1 %h", bus.sdram_req, bus.sdram_addr, addr_v[g]);
        end
        d = $urandom;
        serve(d, 0, 0, a, w);
        model_fill(g, addr_v[g], d);
        cs_v = 4'b0000;
        tick();
    endtask

    task automatic test_ack_rdy_same();
        logic [AW-1:0] a, lat;
        logic [DW-1:0] d;
        int w, g, g2;
        flush_all();
        addr_v[0] = {2'd0, 20'($urandom)};
        addr_v[1] = {2'd1, 20'($urandom)};
        cs_v = 4'b0011;
        g   = exp_grant();
        lat = addr_v[g];
        d   = $urandom;
        serve(d, 1, 1, a, w);
        checks++;
        if (a !== lat || w != 1) begin
            errors++; $display("FAIL same_grant got addr=%h wait=%0d want %h 1", a, w, lat);
        end
        model_fill(g, lat, d);
        checks++;
        if (bus.busy !== 1'b0 || bus.slot_dout[g*DW +: DW] !== m_data[g]) begin
            errors++; $display("FAIL same_fill got busy=%b dout=%h want 0 %h", bus.busy, bus.slot_dout[g*DW +: DW], m_data[g]);
        end
        g2 = exp_grant();
        tick();
        checks++;
        if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== addr_v[g2] || bus.slot_ok[g] !== model_hit(g)) begin
            errors++; $display("FAIL same_next got req=%b addr=%h ok=%b want 1 %h %b",
                               bus.sdram_req, bus.sdram_addr, bus.slot_ok[g], addr_v[g2], model_hit(g));
        end
        lat = addr_v[g2];
        d   = $urandom;
        serve(d, 0, 1, a, w);
        checks++;
        if (a !== lat || w != 0) begin
            errors++; $display("FAIL same_second got addr=%h wait=%0d want %h 0", a, w, lat);
        end
        model_fill(g2, lat, d);
        tick();
        checks++;
        if (bus.slot_ok !== {2'b00, model_hit(1), model_hit(0)} || bus.sdram_req !== 1'b0) begin
            errors++; $display("FAIL same_final got ok=%b req=%b want %b 0", bus.slot_ok, bus.sdram_req, {2'b00, model_hit(1), model_hit(0)});
        end
        cs_v = 4'b0000;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cs_v = 4'b0000;
        for (int n = 0; n < 4; n++) addr_v[n] = '0;
        bus.loop_rst    = 1'b0;
        bus.downloading = 1'b0;
        bus.sdram_ack   = 1'b0;
        bus.data_rdy    = 1'b0;
        bus.data_read   = '0;
        model_reset();
        test_reset();
        test_single_hit();
        test_round_robin();
        test_addr_change();
        test_flush();
        test_ack_rdy_same();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/jtframe_rom_arb.md
# jtframe_rom_arb

Four-slot SDRAM read arbiter and single-entry-per-slot cache. It sits between game-side ROM requesters (CPU, char, scroll, object, sound) and the board SDRAM controller's `sdram_req`/`sdram_ack`/`sdram_addr`/`data_read`/`data_rdy` port. It shares that single request port among the slots using round-robin priority. Each slot keeps its last fetched 32-bit word, so a repeated address is answered without an SDRAM access.

## Interface

Parameters:
- `AW`, 22: SDRAM word-address width. It matches `sdram_addr`.
- `DW`, 32: read-data width. It matches `data_read`.

Ports:
- `clk_rom`  in  1  SDRAM-domain clock. This is the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `loop_rst`  in  1  controller init in progress. Synchronous flush.
- `downloading`  in  1  ROM download active. Synchronous flush and grant inhibit.
- `slot_cs`  in  4  per-slot request enable. Bit n belongs to slot n.
- `slot_addr`  in  4*AW  slot n address is bits [n*AW +: AW].
- `slot_ok`  out  4  slot n data valid for its current address.
- `slot_dout`  out  4*DW  slot n cached word is bits [n*DW +: DW].
- `sdram_req`  out  1  request to the SDRAM controller. Held until `sdram_ack`.
- `sdram_addr`  out  AW  address of the granted request.
- `sdram_ack`  in  1  one-cycle pulse: request accepted.
- `data_read`  in  DW  SDRAM read data.
- `data_rdy`  in  1  one-cycle pulse: `data_read` is valid.
- `busy`  out  1  high in WAIT_ACK and WAIT_RDY.

## Operation

Per-slot state:
- `cache_addr[n]` (AW bits), `cache_data[n]` (DW bits) and `valid[n]`.
- `hit[n]` is defined as `valid[n] & slot_addr[n] == cache_addr[n]`.
- `pend[n]` is defined as `slot_cs[n] & ~hit[n]`.
- Registered output: `slot_ok[n] <= slot_cs[n] & hit[n]`.
- `slot_dout[n]` is driven by `cache_data[n]`.

Arbiter FSM states: IDLE, WAIT_ACK, WAIT_RDY.
- IDLE:
  - If any `pend` is set and `downloading`=0, grant the first pending slot, searching upward from `last+1` modulo 4.
  - On a grant, latch `gnt` and the slot address into `sdram_addr`, set `sdram_req`=1 and go to WAIT_ACK.
  - A slot with no pending request is never granted.
- WAIT_ACK:
  - Keep `sdram_req`=1 and `sdram_addr` stable until `sdram_ack`.
  - On `sdram_ack`, clear `sdram_req` and go to WAIT_RDY.
- WAIT_RDY:
  - On `data_rdy`, set `cache_addr[gnt]` to the latched address, `cache_data[gnt]` to `data_read` and `valid[gnt]` to 1.
  - Set `last` to `gnt` and return to IDLE.
- If `sdram_ack` and `data_rdy` arrive in the same cycle in WAIT_ACK, perform both actions: the cache is filled and the FSM goes to IDLE.
- `data_rdy` or `sdram_ack` received in IDLE is ignored.
- Address change mid-fetch: the fill still stores the latched (old) address. The slot then has no hit, is pending again, and is re-requested in a later round.
- `slot_cs` dropping mid-fetch does not abort the fetch. The fill completes and `slot_ok` stays 0.
- Flush (`loop_rst` or `downloading` high):
  - Synchronous clear of all `valid`, `sdram_req` and `slot_ok`.
  - The FSM goes to IDLE. `last` is preserved.
  - No grant is made while either signal is high.
  - A fetch in flight is abandoned, and a late `data_rdy` is ignored.
- Round robin: in steady state, every continuously pending slot is served within 4 grants.

## Timing

- Reset values:
  - `sdram_req` 0, `sdram_addr` 0, `slot_ok` 0, `slot_dout` 0, `busy` 0.
  - All `valid` and `cache_*` 0.
  - State IDLE.
  - `last` = 3, so slot 0 gets the first grant.
- Grant latency: `sdram_req` rises 1 cycle after `pend` is seen in IDLE.
- Miss latency: let `data_rdy` arrive in cycle t. Then `valid` is set at t+1 and `slot_ok` rises at t+2, provided the address and `cs` are unchanged.
- Hit latency: `slot_ok` rises 1 cycle after `cs` rises with a hitting address.
- Address-change response: `slot_ok` falls 1 cycle after `slot_addr` changes to a non-hitting value.
- Back-to-back requests: the earliest next `sdram_req` is 1 cycle after the `data_rdy` cycle (through IDLE).
- `slot_dout` changes only in the cycle after a fill of that slot.

## Test plan

- **Reset state:** assert `rst` mid-run with `sdram_req`=1. All outputs go to 0 immediately. After release, first request from slots 0 and 2 together: slot 0 is granted first, then slot 2.
- **Single miss then hit:** slot 1 with `cs`=1 and address 0x01234.
  - Required: `sdram_req` rises with `sdram_addr`=0x01234.
  - Send `ack`, then `data_rdy` with data 0xDEADBEEF: `slot_ok[1]`=1 two cycles later and `slot_dout[1]`=0xDEADBEEF.
  - Toggle `cs` low then high: `slot_ok` returns after 1 cycle with no new `sdram_req`.
- **Round robin:** all 4 slots pending with distinct addresses and continuous re-misses. Required grant order: 0, 1, 2, 3, 0, …, with no slot starved.
- **Address change during fetch:** slot 3 changes from 0x100 to 0x200 while in WAIT_RDY.
  - Required: the fill stores 0x100 and `slot_ok[3]` stays 0.
  - The next request for slot 3 carries 0x200.
- **Flush:** pulse `loop_rst` for 1 cycle during WAIT_ACK. Required: `sdram_req` drops, all `valid` bits clear, and a late `data_rdy` does not set `slot_ok`. `downloading`=1 blocks all grants until it is released.
- **Simultaneous ack and rdy:** `sdram_ack` and `data_rdy` in the same cycle. Required: the cache is filled and the FSM returns to IDLE; the next grant follows 1 cycle later.
